range_stream_driver: RTL and testbench
======================================

Name: range_stream_driver

Overview:
- Initiator side of the go/finish sample-stream protocol used by the range finder.
- Buffers up to DEPTH samples written by a host. On start, it replays them to a downstream range-finding receiver: go plus the first sample, then the remaining samples on consecutive cycles, then a finish strobe.
- Captures the receiver's range answer during the finish cycle into a result register and signals done.

Parameters:
- WIDTH, 9, sample and range width in bits.
- DEPTH, 8, sample buffer capacity; must be ≥ 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  append wr_data to the buffer (IDLE only).
- wr_data  input  WIDTH  sample to append.
- clear  input  1  empty the buffer (IDLE only).
- start  input  1  begin a stream transfer (IDLE only).
- range_in  input  WIDTH  range from the receiver; valid only in the cycle finish=1.
- go  output  1  to receiver: first-sample strobe.
- finish  output  1  to receiver: end-of-stream strobe.
- data_out  output  WIDTH  sample to the receiver.
- count  output  $clog2(DEPTH+1)  number of buffered samples.
- busy  output  1  high in SEND_GO, STREAM and FIN.
- result  output  WIDTH  last captured range.
- done  output  1  one-cycle pulse after result updates.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset (asynchronous, active-low):
  - Takes effect immediately, including mid-stream.
  - State=IDLE. go, finish, done, err = 0. data_out=0, count=0, result=0.
  - Buffer contents become don't-care.
- States: IDLE, SEND_GO, STREAM, FIN. Index register idx tracks the sample being sent.
- IDLE:
  - go=0, finish=0, data_out=0.
  - Requests sampled at each rising edge, priority clear > start > wr_en:
    - clear: count←0. Any start or wr_en in the same cycle is ignored, with no err.
    - start with count=0: err pulses in the next cycle; stay IDLE.
    - start with count≥1: idx←0, go to SEND_GO. A wr_en in the same cycle is dropped and err pulses.
    - wr_en alone with count<DEPTH: buf[count]←wr_data, count←count+1.
    - wr_en alone with count=DEPTH: data dropped, err pulses.
- SEND_GO (1 cycle):
  - go=1, finish=0, data_out=buf[0].
  - Next state is STREAM if count≥2 (idx←1), else FIN.
- STREAM:
  - go=0, finish=0, data_out=buf[idx].
  - idx increments each cycle. After idx=count-1 is presented, next state is FIN.
- FIN (1 cycle):
  - go=0, finish=1, data_out=0.
  - At the closing edge: result←range_in, next state IDLE.
  - done=1 during the following cycle (the first IDLE cycle).
- Timing: start sampled at edge k → go high in cycle k+1. Samples occupy cycles k+1 … k+count, finish in cycle k+count+1, done in cycle k+count+2.
- Requests while busy:
  - start and clear are ignored, no err.
  - wr_en is dropped and err pulses.
- Buffer is preserved after a transfer; start again replays the same samples.
- go and finish are never both high, and finish is never high without a preceding go in the same transfer.
- All outputs are registered or decoded from registered state only, with no combinational input-to-output paths. The one exception is that result is captured from range_in.
- Width rule: range_in is taken as-is with no extension or checking. result holds its value until the next FIN.

Test Plan:
- Basic transfer, driver looped to the range receiver: write 5, 20, 3, 12 then start.
  - Required: go with data_out=5 in cycle 1; 20, 3, 12 in cycles 2–4; finish in cycle 5; done in cycle 6 with result=17; busy high in cycles 1–5.
- Single sample: write 100 then start.
  - Required: go with data_out=100, finish in the next cycle, result=0, done one cycle later.
- Empty and full handling:
  - start with count=0 → err pulse, go never asserts.
  - Write 9 values with DEPTH=8 → count=8, err pulses on the 9th write.
- Simultaneous requests:
  - Same-cycle clear+start with count=3 → count=0, no go, no err.
  - Same-cycle start+wr_en with count=2 → transfer of 2 samples, err pulses, count stays 2.
- Busy rejection and replay:
  - wr_en during STREAM → err, count unchanged.
  - After done, start again → identical go/data/finish sequence and the same result.
- Reset mid-stream: deassert reset_n during STREAM.
  - Required: go, finish, busy, count and result all 0 immediately.
  - After release, start with count=0 → err.

Source files
------------

// File: rtl/range_stream_driver.sv
// range_stream_driver
//   Initiator side of the go/finish sample stream. A host fills a small
//   sample buffer while idle. On start, the buffer is replayed to a range
//   receiver: go with the first sample, the remaining samples on the
//   following cycles, then a finish strobe. The receiver's range answer is
//   captured during the finish cycle, and done pulses in the next cycle.
//
// Ports
//   i_clock     rising-edge clock
//   i_reset_n   asynchronous active-low reset
//   i_wr_en     append i_wr_data to the buffer (honoured only in IDLE)
//   i_wr_data   sample to append
//   i_clear     empty the buffer (IDLE only)
//   i_start     begin a transfer (IDLE only)
//   i_range_in  receiver range, sampled only while o_finish=1
//   o_go        first-sample strobe
//   o_finish    end-of-stream strobe
//   o_data_out  sample presented to the receiver (0 when not streaming)
//   o_count     number of buffered samples
//   o_busy      transfer in progress (SEND_GO, STREAM, FIN)
//   o_result    last captured range
//   o_done      one-cycle pulse after o_result updates
//   o_err       one-cycle pulse after a rejected request
module range_stream_driver #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                       i_clock,
   input  logic                       i_reset_n,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_clear,
   input  logic                       i_start,
   input  logic [WIDTH-1:0]           i_range_in,
   output logic                       o_go,
   output logic                       o_finish,
   output logic [WIDTH-1:0]           o_data_out,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_busy,
   output logic [WIDTH-1:0]           o_result,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int CW = $clog2(DEPTH+1);
   // idx only ever addresses 0..DEPTH-1; keep at least one bit for DEPTH=1
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND_GO,
      S_STREAM,
      S_FIN
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_buf [DEPTH];
   logic [CW-1:0]    r_count, w_count_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic             w_buf_we;
   logic [CW-1:0]    w_last;

   assign w_last = r_count - CW'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_idx_nxt    = r_idx;
      w_result_nxt = r_result;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_buf_we     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // priority clear > start > wr_en; clear swallows the others silently
            if (i_clear) begin
               w_count_nxt = '0;
            end else if (i_start) begin
               if (r_count == '0) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_SEND_GO;
                  w_err_nxt   = i_wr_en;   // write lost to the start
               end
            end else if (i_wr_en) begin
               if (r_count == CW'(DEPTH)) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_buf_we    = 1'b1;
                  w_count_nxt = r_count + CW'(1);
               end
            end
         end
         S_SEND_GO: begin
            w_err_nxt = i_wr_en;
            if (r_count >= CW'(2)) begin
               w_idx_nxt   = IW'(1);
               w_state_nxt = S_STREAM;
            end else begin
               w_state_nxt = S_FIN;
            end
         end
         S_STREAM: begin
            w_err_nxt = i_wr_en;
            if (CW'(r_idx) == w_last) begin
               w_state_nxt = S_FIN;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end
         S_FIN: begin
            w_err_nxt    = i_wr_en;
            w_result_nxt = i_range_in;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_idx    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_idx    <= w_idx_nxt;
         r_result <= w_result_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Sample storage carries no reset; contents are meaningless until written.
   always_ff @(posedge i_clock) begin
      if (w_buf_we) r_buf[r_count[IW-1:0]] <= i_wr_data;
   end

   assign o_go       = (r_state == S_SEND_GO);
   assign o_finish   = (r_state == S_FIN);
   assign o_busy     = (r_state != S_IDLE);
   assign o_data_out = (r_state == S_SEND_GO || r_state == S_STREAM) ? r_buf[r_idx] : '0;
   assign o_count    = r_count;
   assign o_result   = r_result;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_range_stream_driver.sv
// Bench for range_stream_driver: a looped range receiver (max - min of the
// streamed samples) answers during finish; a queue model of the buffer
// supplies the expected stream, timing and range.
module tb_range_stream_driver;
   localparam int WIDTH = 9;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int LIM   = DEPTH + 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en, clear, start;
   logic [WIDTH-1:0] wr_data, range_in;
   logic             go, finish, busy, done, err;
   logic [WIDTH-1:0] data_out, result;
   logic [CW-1:0]    count;

   always #5 clk = ~clk;

   range_stream_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_clear(clear), .i_start(start), .i_range_in(range_in),
      .o_go(go), .o_finish(finish), .o_data_out(data_out), .o_count(count),
      .o_busy(busy), .o_result(result), .o_done(done), .o_err(err)
   );

   // Receiver: tracks min/max of the stream, answers only in the finish cycle.
   logic [WIDTH-1:0] rx_min, rx_max, junk;
   always @(posedge clk) begin
      junk <= WIDTH'($urandom);
      if (go) begin
         rx_min <= data_out;
         rx_max <= data_out;
      end else if (busy && !finish) begin
         if (data_out < rx_min) rx_min <= data_out;
         if (data_out > rx_max) rx_max <= data_out;
      end
   end
   assign range_in = finish ? (rx_max - rx_min) : junk;

   int checks = 0, failures = 0;
   int model_q[$];
   int obs_q[$], prev_q[$];
   int go_cyc, fin_cyc, done_cyc, busy_cnt, err_cnt;
   bit bad_strobe;
   logic [WIDTH-1:0] obs_res;

   function automatic int exp_range();
      int mn, mx;
      if (model_q.size() == 0) return 0;
      mn = model_q[0]; mx = model_q[0];
      foreach (model_q[i]) begin
         if (model_q[i] < mn) mn = model_q[i];
         if (model_q[i] > mx) mx = model_q[i];
      end
      return mx - mn;
   endfunction

   function automatic bit same_stream();
      if (obs_q.size() != model_q.size()) return 1'b0;
      foreach (obs_q[i]) if (obs_q[i] != model_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_q.delete();
   endtask

   task automatic do_wr(input int v, output logic e);
      wr_en = 1'b1; wr_data = WIDTH'(v);
      @(negedge clk);
      wr_en = 1'b0;
      e = err;
      if (model_q.size() < DEPTH) model_q.push_back(v);
   endtask

   task automatic load_random(input int n);
      logic e;
      do_clear();
      for (int i = 0; i < n; i++) do_wr(int'($urandom_range(0, (1 << WIDTH) - 1)), e);
   endtask

   // Pulse start, then record what the receiver sees, cycle by cycle
   // (cycle 1 is the one right after start is sampled). wr_en is raised
   // alongside start when wr_at=0, or during cycle wr_at when wr_at>0.
   task automatic capture(input int wr_at);
      obs_q.delete();
      go_cyc = 0; fin_cyc = 0; done_cyc = 0; busy_cnt = 0; err_cnt = 0;
      bad_strobe = 1'b0; obs_res = '0;
      start = 1'b1; wr_en = (wr_at == 0); wr_data = WIDTH'($urandom);
      for (int c = 1; c <= LIM; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (go && go_cyc == 0) go_cyc = c;
         if (go || (busy && !finish)) obs_q.push_back(int'(data_out));
         if (finish && fin_cyc == 0) fin_cyc = c;
         if (finish && go_cyc == 0) bad_strobe = 1'b1;
         if (go && finish) bad_strobe = 1'b1;
         if (busy) busy_cnt++;
         if (err) err_cnt++;
         wr_en = (c == wr_at);
         if (done) begin
            done_cyc = c; obs_res = result;
            break;
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 0; clear = 0; start = 0; wr_data = '0;
      #12;
      checks++;
      if ({go, finish, busy, done, err} !== 5'b0 || data_out !== '0 || count !== '0 || result !== '0) begin
         failures++;
         $display("FAIL reset_state go=%b fin=%b busy=%b done=%b err=%b data=%0d count=%0d result=%0d, all required 0",
                  go, finish, busy, done, err, data_out, count, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || count !== '0) begin
         failures++;
         $display("FAIL reset_release busy=%b count=%0d, required 0/0", busy, count);
      end
   endtask

   task automatic test_basic();
      logic e;
      int vals[4] = '{5, 20, 3, 12};
      do_clear();
      foreach (vals[i]) begin
         do_wr(vals[i], e);
         checks++;
         if (e !== 1'b0) begin failures++; $display("FAIL basic_wr_err write %0d err=%b, required 0", i, e); end
      end
      checks++;
      if (count !== CW'(4)) begin failures++; $display("FAIL basic_count got %0d, required 4", count); end
      capture(-1);
      checks++;
      if (go_cyc !== 1 || fin_cyc !== 5 || done_cyc !== 6) begin
         failures++;
         $display("FAIL basic_timing go=%0d fin=%0d done=%0d, required 1/5/6", go_cyc, fin_cyc, done_cyc);
      end
      checks++;
      if (!same_stream()) begin failures++; $display("FAIL basic_data got %p, required %p", obs_q, model_q); end
      checks++;
      if (obs_res !== WIDTH'(17)) begin failures++; $display("FAIL basic_result got %0d, required 17", obs_res); end
      checks++;
      if (busy_cnt !== 5 || bad_strobe || err_cnt !== 0) begin
         failures++;
         $display("FAIL basic_busy busy_cycles=%0d bad_strobe=%b errs=%0d, required 5/0/0", busy_cnt, bad_strobe, err_cnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || count !== CW'(4) || result !== WIDTH'(17)) begin
         failures++;
         $display("FAIL basic_after done=%b count=%0d result=%0d, required 0/4/17", done, count, result);
      end
   endtask

   task automatic test_single();
      logic e;
      do_clear();
      do_wr(100, e);
      checks++;
      if (result !== WIDTH'(17)) begin failures++; $display("FAIL single_hold result=%0d, required 17", result); end
      capture(-1);
      checks++;
      if (go_cyc !== 1 || fin_cyc !== 2 || done_cyc !== 3 || bad_strobe) begin
         failures++;
         $display("FAIL single_timing go=%0d fin=%0d done=%0d bad=%b, required 1/2/3/0", go_cyc, fin_cyc, done_cyc, bad_strobe);
      end
      checks++;
      if (!same_stream() || obs_res !== '0) begin
         failures++;
         $display("FAIL single_data got %p result=%0d, required %p result=0", obs_q, obs_res, model_q);
      end
   endtask

   task automatic test_empty_full();
      logic e;
      do_clear();
      capture(-1);
      checks++;
      if (go_cyc !== 0 || err_cnt !== 1 || busy_cnt !== 0 || done_cyc !== 0) begin
         failures++;
         $display("FAIL empty_start go=%0d errs=%0d busy=%0d done=%0d, required 0/1/0/0", go_cyc, err_cnt, busy_cnt, done_cyc);
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         do_wr(int'($urandom_range(0, (1 << WIDTH) - 1)), e);
         checks++;
         if (e !== (i == DEPTH)) begin
            failures++;
            $display("FAIL full_wr_err write %0d err=%b, required %b", i, e, (i == DEPTH));
         end
      end
      checks++;
      if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got %0d, required %0d", count, DEPTH); end
      capture(-1);
      checks++;
      if (!same_stream() || fin_cyc !== DEPTH + 1 || done_cyc !== DEPTH + 2 || obs_res !== WIDTH'(exp_range())) begin
         failures++;
         $display("FAIL full_stream got %p fin=%0d done=%0d res=%0d, required %p %0d/%0d res=%0d",
                  obs_q, fin_cyc, done_cyc, obs_res, model_q, DEPTH + 1, DEPTH + 2, exp_range());
      end
   endtask

   task automatic test_simultaneous();
      load_random(3);
      clear = 1'b1; start = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      model_q.delete();
      checks++;
      if (count !== '0 || err !== 1'b0 || go !== 1'b0) begin
         failures++;
         $display("FAIL clear_start count=%0d err=%b go=%b, required 0/0/0", count, err, go);
      end
      @(negedge clk);
      checks++;
      if (go !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL clear_start_next go=%b busy=%b err=%b, required 0/0/0", go, busy, err);
      end
      load_random(2);
      capture(0);
      checks++;
      if (!same_stream() || err_cnt !== 1 || fin_cyc !== 3 || done_cyc !== 4 || count !== CW'(2)) begin
         failures++;
         $display("FAIL start_wr got %p errs=%0d fin=%0d done=%0d count=%0d, required %p 1/3/4/2",
                  obs_q, err_cnt, fin_cyc, done_cyc, count, model_q);
      end
   endtask

   task automatic test_busy_replay();
      logic [WIDTH-1:0] prev_res;
      int prev_fin;
      bit same;
      load_random(4);
      capture(2);
      checks++;
      if (!same_stream() || err_cnt !== 1 || count !== CW'(4) || obs_res !== WIDTH'(exp_range())) begin
         failures++;
         $display("FAIL busy_wr got %p errs=%0d count=%0d res=%0d, required %p 1/4 res=%0d",
                  obs_q, err_cnt, count, obs_res, model_q, exp_range());
      end
      prev_q = obs_q; prev_res = obs_res; prev_fin = fin_cyc;
      capture(-1);
      same = (obs_q.size() == prev_q.size());
      foreach (obs_q[i]) if (i < prev_q.size() && obs_q[i] != prev_q[i]) same = 1'b0;
      checks++;
      if (!same || obs_res !== prev_res || fin_cyc !== prev_fin || go_cyc !== 1) begin
         failures++;
         $display("FAIL replay got %p res=%0d fin=%0d, required %p res=%0d fin=%0d", obs_q, obs_res, fin_cyc, prev_q, prev_res, prev_fin);
      end
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 5; t++) begin
         n = int'($urandom_range(1, DEPTH));
         load_random(n);
         capture(-1);
         checks++;
         if (!same_stream() || go_cyc !== 1 || fin_cyc !== n + 1 || done_cyc !== n + 2 ||
             busy_cnt !== n + 1 || bad_strobe || obs_res !== WIDTH'(exp_range())) begin
            failures++;
            $display("FAIL random_%0d n=%0d got %p go=%0d fin=%0d done=%0d busy=%0d res=%0d, required %p res=%0d",
                     t, n, obs_q, go_cyc, fin_cyc, done_cyc, busy_cnt, obs_res, model_q, exp_range());
         end
      end
   endtask

   task automatic test_reset_mid();
      logic e;
      do_clear();
      do_wr(1, e); do_wr(300, e); do_wr(7, e); do_wr(40, e); do_wr(2, e);
      capture(-1);   // leaves a non-zero result behind
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);   // cycle 2: streaming
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({go, finish, busy} !== 3'b0 || count !== '0 || result !== '0 || data_out !== '0) begin
         failures++;
         $display("FAIL reset_mid go=%b fin=%b busy=%b count=%0d result=%0d data=%0d, required all 0",
                  go, finish, busy, count, result, data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_q.delete();
      capture(-1);
      checks++;
      if (go_cyc !== 0 || err_cnt !== 1 || busy_cnt !== 0) begin
         failures++;
         $display("FAIL reset_mid_start go=%0d errs=%0d busy=%0d, required 0/1/0", go_cyc, err_cnt, busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_empty_full();
      test_simultaneous();
      test_busy_replay();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
